// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: refill sequencer for one L1 cache bank.
//
// Accepts a miss from the bank and issues one line-read request to memory.
// It then streams BANK_NUM returned beats into the bank's refill write port
// and pulses finish_rd so the bank can mark the line valid.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   miss_cache, addr_cache,   miss request, line-aligned miss address and
//   set_cache                 victim way from the bank
//   busy_rd                   refill in progress (REQ, DATA, DONE)
//   addr_rd, data_rd, wen_rd  bank refill write port for the current beat
//   set_rd                    latched victim way
//   finish_rd                 one-cycle pulse when the line is complete
//   mem_req, mem_addr,        line-read request to memory, held until grant
//   mem_gnt
//   mem_rvalid, mem_rdata     returned read beats, ascending word order
//   miss_count                refills completed since reset (wraps)
module cache_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BANK_NUM   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_cache,
  input  logic [ADDR_WIDTH-1:0] addr_cache,
  input  logic                  set_cache,
  output logic                  busy_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic                  wen_rd,
  output logic                  set_rd,
  output logic                  finish_rd,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           miss_count
);

  localparam int unsigned BeatW     = $clog2(BANK_NUM);
  localparam int unsigned BeatBytes = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StReq, StData, StDone} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic                    way_q;
  logic [BeatW-1:0]        beat_q;
  logic [31:0]             count_q;
  logic                    busy_q;
  logic                    req_q;
  logic                    finish_q;
  logic [ADDR_WIDTH-1:0]   beat_off;

  // busy/req/finish are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      base_q   <= '0;
      way_q    <= 1'b0;
      beat_q   <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      req_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (miss_cache) begin
            base_q  <= addr_cache;
            way_q   <= set_cache;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (mem_gnt) begin
            req_q   <= 1'b0;
            state_q <= StData;
          end
        end
        StData: begin
          if (mem_rvalid) begin
            // beat wraps to 0 on the last beat, so DONE presents base again.
            beat_q <= beat_q + 1'b1;
            if (beat_q == BeatW'(BANK_NUM - 1)) begin
              finish_q <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StDone: begin
          finish_q <= 1'b0;
          busy_q   <= 1'b0;
          count_q  <= count_q + 32'd1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign beat_off   = ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BeatBytes);
  assign addr_rd    = busy_q ? (base_q + beat_off) : '0;
  assign mem_addr   = req_q ? base_q : '0;
  assign wen_rd     = (state_q == StData) & mem_rvalid;
  assign data_rd    = wen_rd ? mem_rdata : '0;
  assign busy_rd    = busy_q;
  assign mem_req    = req_q;
  assign finish_rd  = finish_q;
  assign set_rd     = way_q;
  assign miss_count = count_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed refills with literal
// expectations plus randomized refills checked every cycle against a
// transaction-level model of a refill.
module tb_cache_refill_ctrl;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          miss_cache = 1'b0;
  logic [AW-1:0] addr_cache = '0;
  logic          set_cache = 1'b0;
  logic          busy_rd;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] data_rd;
  logic          wen_rd;
  logic          set_rd;
  logic          finish_rd;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [31:0]   miss_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [63:0] pin_addr [4] = '{64'h1000, 64'h1008, 64'h1010, 64'h1018};
  logic [63:0] pin_data [4] = '{64'hD0D0_0000_0000_00D0, 64'hD1D1_1111_1111_11D1,
                                64'hD2D2_2222_2222_22D2, 64'hD3D3_3333_3333_33D3};

  cache_refill_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BANK_NUM  (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .miss_cache(miss_cache),
    .addr_cache(addr_cache),
    .set_cache (set_cache),
    .busy_rd   (busy_rd),
    .addr_rd   (addr_rd),
    .data_rd   (data_rd),
    .wen_rd    (wen_rd),
    .set_rd    (set_rd),
    .finish_rd (finish_rd),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Line is N words of 8 bytes = 32 bytes.
  function automatic logic [63:0] rnd_line();
    return rnd64() & ~64'h1F;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: a refill is "active" from the accepted miss until the
  // cycle after its last beat; it is "granted" once memory has accepted the
  // request, and counts beats taken. Checked on every falling edge.
  // ---------------------------------------------------------------------------
  logic        m_active;
  logic        m_granted;
  int          m_beats;
  logic [63:0] m_base;
  logic        m_way;
  logic [31:0] m_count;

  initial begin
    logic        e_req, e_fin, e_wen;
    logic [63:0] e_data, e_addr;
    m_active = 1'b0; m_granted = 1'b0; m_beats = 0;
    m_base = '0; m_way = 1'b0; m_count = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_active = 1'b0; m_granted = 1'b0; m_beats = 0;
        m_base = '0; m_way = 1'b0; m_count = '0;
        check("rst_busy", busy_rd, 0);
        check("rst_req", mem_req, 0);
        check("rst_finish", finish_rd, 0);
        check("rst_wen", wen_rd, 0);
        check("rst_addr", addr_rd, 0);
        check("rst_count", miss_count, 0);
      end else begin
        e_req  = m_active && !m_granted;
        e_fin  = m_active && (m_beats == N);
        e_wen  = m_active && m_granted && (m_beats < N) && mem_rvalid;
        e_data = e_wen ? mem_rdata : 64'h0;
        e_addr = m_base + 64'((m_beats % N) * (DW / 8));
        check("busy_rd", busy_rd, m_active);
        check("mem_req", mem_req, e_req);
        check("finish_rd", finish_rd, e_fin);
        check("wen_rd", wen_rd, e_wen);
        check("data_rd", data_rd, e_data);
        check("set_rd", set_rd, m_way);
        check("miss_count", miss_count, m_count);
        if (m_active) check("addr_rd", addr_rd, e_addr);
        if (e_req) check("mem_addr", mem_addr, m_base);
        // Advance to what the next rising edge produces.
        if (!m_active) begin
          if (miss_cache) begin
            m_active = 1'b1; m_granted = 1'b0; m_beats = 0;
            m_base = addr_cache; m_way = set_cache;
          end
        end else if (!m_granted) begin
          if (mem_gnt) m_granted = 1'b1;
        end else if (m_beats < N) begin
          if (mem_rvalid) m_beats++;
        end else begin
          m_active = 1'b0;
          m_count  = m_count + 32'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One refill: gap < 0 picks random inter-beat gaps; noise drives stray
  // rvalid while the request is pending and during the completion cycle.
  task automatic refill(input logic [63:0] a, input logic w, input int gdly, input int gap,
                        input bit noise, input bit hold, input bit pin);
    int g;
    step();
    miss_cache = 1'b1; addr_cache = a; set_cache = w;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int i = 0; i <= gdly; i++) begin
      step();
      miss_cache = hold;
      if (hold) addr_cache = rnd_line();
      mem_gnt    = (i == gdly);
      mem_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata  = rnd64();
    end
    for (int b = 0; b < N; b++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int k = 0; k < g; k++) begin
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = rnd64();
      end
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1;
      mem_rdata = pin ? pin_data[b] : rnd64();
      if (pin) begin
        #1;
        check("pin_wen", wen_rd, 1);
        check("pin_addr", addr_rd, pin_addr[b]);
        check("pin_data", data_rd, pin_data[b]);
        check("pin_set", set_rd, 1);
      end
    end
    step();
    miss_cache = hold;
    mem_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_rdata  = rnd64();
    if (pin) begin
      #1;
      check("pin_finish", finish_rd, 1);
      check("pin_busy_done", busy_rd, 1);
      check("pin_addr_done", addr_rd, 64'h1000);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #3;
    check("init_busy", busy_rd, 0);
    check("init_req", mem_req, 0);
    check("init_count", miss_count, 0);
    check("init_set", set_rd, 0);
    step();
    step();
    rst = 1'b0;

    // Directed: 0x1000, way 1, grant after 2 cycles, contiguous beats.
    refill(64'h1000, 1'b1, 2, 0, 1'b0, 1'b0, 1'b1);
    step();
    check("pin_finish_gone", finish_rd, 0);
    check("pin_count_one", miss_count, 1);

    // One-cycle gaps between beats and stray rvalid while requesting.
    refill(64'h4_0040, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0);

    // miss_cache held high through back-to-back refills.
    refill(rnd_line(), 1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    refill(rnd_line(), 1'b0, 1, 0, 1'b0, 1'b1, 1'b0);
    step();
    miss_cache = 1'b0;

    for (int r = 0; r < 30; r++) begin
      refill(rnd_line(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), -1,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    step();
    miss_cache = 1'b0;
    step();

    // Reset between edges after two beats aborts the refill.
    step();
    miss_cache = 1'b1; addr_cache = 64'h2000; set_cache = 1'b0;
    step();
    miss_cache = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rnd64();
    step();
    mem_rdata = rnd64();
    step();
    mem_rvalid = 1'b0;
    #1;
    check("abort_busy_before", busy_rd, 1);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", busy_rd, 0);
    check("abort_req", mem_req, 0);
    check("abort_finish", finish_rd, 0);
    check("abort_count", miss_count, 0);
    step();
    step();
    rst = 1'b0;

    // A fresh refill after the abort starts from beat 0.
    refill(64'h1000, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    step();
    check("after_abort_count", miss_count, 1);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
